fetch_stage: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register for the RV32I pipelined core. It owns the program counter and issues one word-aligned request at a time to instruction memory. Responses are captured into the IF/ID register, whose instruction word drives the decode stage (control unit and immediate generator). It absorbs hazard-unit stalls with a one-entry buffer and handles branch/jump redirects by squashing in-flight and buffered fetches.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at a time,
// and feeds the IF/ID pipeline register through a one-entry stall buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_BUF  = 2'd2,
        S_KILL = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_v_q, buf_v_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        accept;
    logic        resp;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect overrides everything; a response still in flight must be swallowed in KILL.
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            if ((state_q == S_WAIT || state_q == S_KILL) && !imem_rvalid_i) begin
                state_d = S_KILL;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ:  if (accept) state_d = S_WAIT;
                S_WAIT: if (imem_rvalid_i) state_d = stall_i ? S_BUF : S_REQ;
                S_BUF:  if (!stall_i) state_d = S_REQ;
                S_KILL: if (imem_rvalid_i) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req_o  = (state_q == S_REQ) && !redirect_i;
        imem_addr_o = pc_q;
        accept      = imem_req_o && imem_ready_i;
        resp        = (state_q == S_WAIT) && imem_rvalid_i;
    end

    always_comb begin
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        buf_v_d    = buf_v_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            buf_v_d    = 1'b0;
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
        end else begin
            if (accept) fetch_pc_d = pc_q;
            if (resp) begin
                pc_d = fetch_pc_q + 32'd4;
                if (stall_i) begin
                    buf_d    = imem_rdata_i;
                    buf_pc_d = fetch_pc_q;
                    buf_v_d  = 1'b1;
                end
            end
            if (!stall_i) begin
                if (resp) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = fetch_pc_q;
                    id_instr_d = imem_rdata_i;
                end else if (state_q == S_BUF && buf_v_q) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = buf_pc_q;
                    id_instr_d = buf_q;
                    buf_v_d    = 1'b0;
                end else begin
                    // Bubble: the pc fields keep their last value.
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            fetch_pc_q <= '0;
            buf_q      <= '0;
            buf_pc_q   <= '0;
            buf_v_q    <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
        end else begin
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
            buf_v_q    <= buf_v_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign if_id_valid_o = id_valid_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_pc4_o   = id_pc_q + 32'd4;
    assign if_id_instr_o = id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural instruction memory, a request/IF-ID scoreboard,
// a cycle table for streaming and stalls, and directed redirect/wrap/reset sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;

    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned mem_lat;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } id_t;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    logic [31:0] req_q[$];
    id_t         id_q[$];
    vec_t        tbl[12];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_id_valid_o(if_id_valid_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_pc4_o  (if_id_pc4_o),
        .if_id_instr_o(if_id_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00a0_0113;
            default:       return {a[24:0], 7'h13};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a);
        req_q.push_back(a);
    endtask

    task automatic push_id(input logic [31:0] a);
        id_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        id_q.push_back(e);
    endtask

    // Instruction memory: one pending request, response mem_lat cycles after acceptance.
    initial begin : memory
        logic        pend;
        logic [31:0] pend_addr;
        int unsigned pend_cnt;
        pend = 1'b0;
        pend_addr = '0;
        pend_cnt = 0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_o && imem_ready_i) begin
                pend = 1'b1;
                pend_addr = imem_addr_o;
                pend_cnt = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = mem_word(pend_addr);
                    pend = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every accepted request and every newly loaded IF/ID entry pops an expectation.
    initial begin : monitor
        logic stall_used;
        id_t  e;
        stall_used = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_used = 1'b1;
            end else begin
                if (imem_req_o && imem_ready_i) begin
                    if (req_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_req: got request %h expected none", imem_addr_o);
                    end else begin
                        chk("sb_req_addr", imem_addr_o, req_q.pop_front());
                    end
                end
                if (if_id_valid_o && !stall_used) begin
                    if (id_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_ifid: got pc %h instr %h expected no instruction",
                                 if_id_pc_o, if_id_instr_o);
                    end else begin
                        e = id_q.pop_front();
                        chk("sb_ifid_pc", if_id_pc_o, e.pc);
                        chk("sb_ifid_instr", if_id_instr_o, e.instr);
                        chk("sb_ifid_pc4", if_id_pc4_o, e.pc + 32'd4);
                    end
                end
                stall_used = stall_i;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        n_chk = 0;
        n_pass = 0;
        mem_lat = 1;
        rst_n = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_ready_i = 1'b0;

        //          stall ready req addr          valid pc            instr
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,  NOP};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  NOP};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0,  32'h0050_0093};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  NOP};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4,  32'h00a0_0113};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h00a0_0113};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h00a0_0113};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h00a0_0113};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8,  32'h0000_0413};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h8,  NOP};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'hC,  32'h0000_0613};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'hC,  NOP};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("rst_pc", if_id_pc_o, 32'h0);
        chk("rst_pc4", if_id_pc4_o, 32'h4);
        chk("rst_instr", if_id_instr_o, NOP);
        chk("rst_addr", imem_addr_o, 32'h0);

        // Streaming with zero wait states, then a 3-cycle stall that parks a response.
        push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
        push_id(32'h0);  push_id(32'h4);  push_id(32'h8);  push_id(32'hC);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stall_i = tbl[i].stall;
            imem_ready_i = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("row%0d_req", i), {31'd0, imem_req_o}, {31'd0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].addr);
            chk($sformatf("row%0d_valid", i), {31'd0, if_id_valid_o}, {31'd0, tbl[i].valid});
            chk($sformatf("row%0d_pc", i), if_id_pc_o, tbl[i].pc);
            chk($sformatf("row%0d_instr", i), if_id_instr_o, tbl[i].instr);
            tick();
        end

        // Redirect while WAIT; the stale response lands a cycle later and must be killed.
        mem_lat = 2;
        imem_ready_i = 1'b1;
        push_req(32'h10);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        push_req(32'h100);
        push_id(32'h100);
        @(negedge clk);
        chk("kill_req", {31'd0, imem_req_o}, 32'd0);
        chk("kill_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("kill_pc", if_id_pc_o, 32'h0);
        chk("kill_instr", if_id_instr_o, NOP);
        tick();
        @(negedge clk);
        chk("redir_req", {31'd0, imem_req_o}, 32'd1);
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_valid", {31'd0, if_id_valid_o}, 32'd0);
        tick();
        imem_ready_i = 1'b0;
        tick();
        tick();
        mem_lat = 1;
        tick();

        // Redirect coinciding with a stalled response, then a redirect with the buffer full.
        imem_ready_i = 1'b1;
        push_req(32'h104);
        tick();
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        push_req(32'h200);
        tick();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        chk("rv_redir_addr", imem_addr_o, 32'h200);
        chk("rv_redir_req", {31'd0, imem_req_o}, 32'd1);
        chk("rv_redir_instr", if_id_instr_o, NOP);
        tick();
        stall_i = 1'b1;
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        @(negedge clk);
        chk("buf_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        imem_ready_i = 1'b0;
        @(negedge clk);
        chk("buf_redir_req", {31'd0, imem_req_o}, 32'd1);
        chk("buf_redir_addr", imem_addr_o, 32'h300);
        chk("buf_redir_valid", {31'd0, if_id_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("buf_dropped_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("buf_dropped_instr", if_id_instr_o, NOP);
        tick();

        // Address wrap; low target bits are discarded and the request is masked during redirect.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("redir_mask_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        imem_ready_i = 1'b1;
        push_req(32'hFFFF_FFFC);
        push_id(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        tick();
        push_req(32'h0);
        push_id(32'h0);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr_o, 32'h0);
        chk("wrap_pc", if_id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc4_o, 32'h0);
        tick();
        imem_ready_i = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_after_valid", {31'd0, if_id_valid_o}, 32'd1);
        chk("wrap_after_instr", if_id_instr_o, 32'h0050_0093);
        tick();

        // Asynchronous reset while a request is outstanding.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        tick();
        redirect_i = 1'b0;
        imem_ready_i = 1'b1;
        push_req(32'h40);
        push_id(32'h40);
        tick();
        mem_lat = 2;
        tick();
        push_req(32'h44);
        stall_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, if_id_valid_o}, 32'd1);
        chk("pre_rst_pc", if_id_pc_o, 32'h40);
        tick();
        imem_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_id_valid_o}, 32'd0);
        chk("arst_pc", if_id_pc_o, 32'h0);
        chk("arst_pc4", if_id_pc4_o, 32'h4);
        chk("arst_instr", if_id_instr_o, NOP);
        chk("arst_addr", imem_addr_o, 32'h0);
        stall_i = 1'b0;
        tick();
        tick();
        mem_lat = 1;
        imem_ready_i = 1'b1;
        push_req(32'h0);
        push_id(32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'd0, imem_req_o}, 32'd1);
        chk("restart_addr", imem_addr_o, 32'h0);
        tick();
        imem_ready_i = 1'b0;
        tick();
        @(negedge clk);
        chk("restart_ifid_pc", if_id_pc_o, 32'h0);
        chk("restart_ifid_instr", if_id_instr_o, 32'h0050_0093);
        tick();
        tick();

        chk("sb_req_left", req_q.size(), 32'd0);
        chk("sb_ifid_left", id_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
